fp_align_stage: RTL
===================

# fp_align_stage

Two-stage pipelined operand-alignment front end for the single-precision FP adder/subtractor. It unpacks two IEEE-754 binary32 operands and orders them by magnitude, so that the first output operand is never smaller than the second. It computes the exponent difference and right-shifts the smaller significand into the larger one's scale using the `right_shift` sub-module, collecting a sticky bit from the discarded bits. Its output feeds the significand add/normalise stage through a valid/ready handshake.

## Interface
- No parameters; all widths are fixed by binary32.
- `CLK` input 1 — sole clock, rising edge.
- `nRST` input 1 — asynchronous, active-low reset.
- `flush` input 1 — synchronous; kills all in-flight operations.
- `in_valid` input 1 — an operand pair is offered.
- `in_ready` output 1 — the stage accepts the offered pair this cycle.
- `op_a` input 32 — binary32 operand A.
- `op_b` input 32 — binary32 operand B.
- `sub` input 1 — 1 = A−B (B's sign is inverted at capture).
- `out_valid` output 1 — aligned result is available.
- `out_ready` input 1 — downstream consumes the result this cycle.
- `sign_large` output 1 — sign of the larger-magnitude operand.
- `eff_sub` output 1 — effective subtraction (the two effective signs differ).
- `exp_max` output 8 — effective exponent of the larger operand.
- `frac_large` output 26 — larger significand, unshifted.
- `frac_small` output 26 — smaller significand after the right shift.
- `sticky` output 1 — OR of all bits shifted out of `frac_small`.
- `special` output 1 — at least one operand has exponent 255 (Inf/NaN).

## Operation
- **Significand format (26 bits):** `{1'b0, hidden, frac[22:0], 1'b0}`.
  - Bit 25 is carry headroom, bit 24 is the hidden bit, bit 0 is the guard bit.
  - hidden = 1 when exp ≠ 0.
  - A subnormal (exp = 0) has hidden = 0 and effective exponent 1.
- **Stage 1 (capture):**
  - Compute effective sign for B: `sign_b ^ sub`.
  - Compute effective exponents and significands.
  - Swap operands when `exp_b > exp_a`, or when `exp_b == exp_a` and `frac_b > frac_a`. Equal magnitudes do not swap.
  - Compute `shamt = exp_large − exp_small`, 8-bit unsigned, range 0..254.
  - Compute `eff_sub`.
  - Compute `special`.
  - Register all of the above.
- **Stage 2 (align):**
  - `frac_small = right_shift(frac_small_pre, shamt)`. Any `shamt` ≥ 26 gives 0.
  - `sticky` = OR of `frac_small_pre[min(shamt,26)−1:0]`. `sticky` is 0 when `shamt` = 0.
  - Register the result into the output stage.
- For special operands the alignment fields are still computed normally. Downstream decides the result from `special`.
- **Handshake:**
  - `adv2 = v2 ? out_ready : 1`.
  - `adv1 = !v1 || adv2`.
  - `in_ready = adv1`.
  - Stage 1 loads when `in_valid && in_ready`.
  - Stage 2 loads from stage 1 when `v1 && adv2`.
  - `out_valid = v2`.
- **Flush:** `v1` and `v2` clear at the next edge, even under a simultaneous load. The pair offered in the flush cycle is dropped, and `in_ready` may still read 1 during that cycle.
- **Reset:** `v1`, `v2`, and all output payload registers go to 0. The output payload is 0 while `out_valid` = 0 after reset.

## Timing
- Latency is 2 cycles: a pair accepted at edge N appears with `out_valid` = 1 after edge N+1.
- Throughput is one pair per cycle while `out_ready` = 1.
- While `out_valid && !out_ready`, every output payload bit holds stable.
- Backpressure: a full pipeline holds 2 pairs, and `in_ready` drops combinationally once both stages are occupied and `out_ready` = 0.
- Simultaneous output consume and input accept on a full pipeline is allowed with no bubble: `in_ready` = 1 when `out_ready` = 1.
- `nRST` asserted mid-operation clears everything immediately, asynchronously. Outputs stay 0 until 2 cycles after the first accept following release.

## Structure
- The shared FPU package holds:
  - `localparam` widths: `FRAC_W = 26`, `EXP_W = 8`.
  - `EXP_SPECIAL = 8'hFF`.
  - A packed struct `fp_aligned_t` holding the output payload, reused by the add/normalise stage.
- One sub-module: the existing `right_shift`, instantiated in stage 2.
- The sticky mask is local logic in this block.

## Test plan
- 1.0 + 0.5 (`op_a=32'h3F800000`, `op_b=32'h3F000000`, `sub=0`) → `exp_max=127`, `frac_large=26'h1000000`, `frac_small=26'h0800000`, `sticky=0`, `eff_sub=0`, `out_valid` 2 cycles after accept.
- 1.0 + 2⁻³⁰ (`op_b=32'h30800000`) → `shamt=30`, `frac_small=0`, `sticky=1`, `exp_max=127`.
- 0.5 + (−1.0) (`op_a=32'h3F000000`, `op_b=32'hBF800000`) → swap, `sign_large=1`, `eff_sub=1`, `frac_small=26'h0800000`.
- Equal magnitude 1.0 − 1.0 (`sub=1`) → no swap, `shamt=0`, `frac_small=frac_large=26'h1000000`, `sticky=0`, `sign_large=0`, `eff_sub=1`.
- Backpressure: hold `out_ready=0`, offer 3 pairs → 2 accepted, `in_ready=0` on the third, output stable; raise `out_ready` → all 3 emerge in order, one per cycle.
- Flush with 2 in flight → `out_valid=0` next cycle, nothing emerges. `nRST` pulse mid-stream → all outputs 0 immediately. `op_a=32'h7F800000` → `special=1`.

Source files
------------

// File: rtl/fp_align_stage_pkg.sv
// Shared FPU definitions: binary32 widths, the aligned-operand payload
// handed to the add/normalise stage, and operand unpack helpers.
package fp_align_stage_pkg;

  localparam int FRAC_W = 26;
  localparam int EXP_W  = 8;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  // Output payload of the alignment stage, consumed by add/normalise.
  typedef struct packed {
    logic              sign_large;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp_max;
    logic [FRAC_W-1:0] frac_large;
    logic [FRAC_W-1:0] frac_small;
    logic              sticky;
    logic              special;
  } fp_aligned_t;

  // Ordered operands held between capture and align.
  typedef struct packed {
    logic              sign_large;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp_max;
    logic [FRAC_W-1:0] frac_large;
    logic [FRAC_W-1:0] frac_small_pre;
    logic [EXP_W-1:0]  shamt;
    logic              special;
  } fp_ordered_t;

  // Subnormals share the scale of exponent 1.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? 8'd1 : e;
  endfunction

  // {headroom, hidden, fraction, guard}
  function automatic logic [FRAC_W-1:0] unpack_frac(input logic [EXP_W-1:0] e,
                                                    input logic [22:0] f);
    return {1'b0, (e != '0), f, 1'b0};
  endfunction

endpackage

// File: rtl/fp_align_stage_right_shift.sv
// Logical right shift of a significand; shifts past its width give zero.
module right_shift
  import fp_align_stage_pkg::*;
(
  input  logic [FRAC_W-1:0] din_i,
  input  logic [EXP_W-1:0]  shamt_i,
  output logic [FRAC_W-1:0] dout_o
);

  // Saturate large shift amounts to an all-zero result.
  always_comb begin
    dout_o = '0;
    if (shamt_i < 8'(FRAC_W)) dout_o = din_i >> shamt_i;
  end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage binary32 operand alignment: stage 1 unpacks and orders the
// operands by magnitude, stage 2 right-shifts the smaller significand and
// collects the sticky bit. Valid/ready on both sides.
module fp_align_stage
  import fp_align_stage_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_large,
  output logic              eff_sub,
  output logic [EXP_W-1:0]  exp_max,
  output logic [FRAC_W-1:0] frac_large,
  output logic [FRAC_W-1:0] frac_small,
  output logic              sticky,
  output logic              special
);

  logic [2:1]  vld_q, vld_d;
  fp_ordered_t s1_q, s1_d;
  fp_aligned_t out_q, out_d;
  logic        adv1, adv2, load1, load2;

  logic              sa, sb, swap;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic [FRAC_W-1:0] shifted, mask;

  // Handshake: a stage advances when its successor is empty or draining.
  always_comb begin
    adv2  = vld_q[2] ? out_ready : 1'b1;
    adv1  = !vld_q[1] || adv2;
    load1 = in_valid && adv1;
    load2 = vld_q[1] && adv2;
    vld_d[1] = load1 || (vld_q[1] && !adv2);
    vld_d[2] = load2 || (vld_q[2] && !out_ready);
    if (flush) vld_d = '0;
  end

  assign in_ready = adv1;

  // Stage 1: unpack, order by magnitude (ties keep A first), exponent diff.
  always_comb begin
    sa   = op_a[31];
    sb   = op_b[31] ^ sub;
    ea   = eff_exp(op_a[30:23]);
    eb   = eff_exp(op_b[30:23]);
    fa   = unpack_frac(op_a[30:23], op_a[22:0]);
    fb   = unpack_frac(op_b[30:23], op_b[22:0]);
    swap = (eb > ea) || ((eb == ea) && (fb > fa));
    s1_d = '0;
    s1_d.eff_sub = sa ^ sb;
    s1_d.special = (op_a[30:23] == EXP_SPECIAL) || (op_b[30:23] == EXP_SPECIAL);
    if (swap) begin
      s1_d.sign_large     = sb;
      s1_d.exp_max        = eb;
      s1_d.frac_large     = fb;
      s1_d.frac_small_pre = fa;
      s1_d.shamt          = eb - ea;
    end else begin
      s1_d.sign_large     = sa;
      s1_d.exp_max        = ea;
      s1_d.frac_large     = fa;
      s1_d.frac_small_pre = fb;
      s1_d.shamt          = ea - eb;
    end
  end

  right_shift u_rshift (
    .din_i   (s1_q.frac_small_pre),
    .shamt_i (s1_q.shamt),
    .dout_o  (shifted)
  );

  // Stage 2: mask covers exactly the bits the shifter discards.
  always_comb begin
    mask = '1;
    if (s1_q.shamt < 8'(FRAC_W)) mask = (26'd1 << s1_q.shamt) - 26'd1;
    out_d            = '0;
    out_d.sign_large = s1_q.sign_large;
    out_d.eff_sub    = s1_q.eff_sub;
    out_d.exp_max    = s1_q.exp_max;
    out_d.frac_large = s1_q.frac_large;
    out_d.frac_small = shifted;
    out_d.sticky     = |(s1_q.frac_small_pre & mask);
    out_d.special    = s1_q.special;
  end

  // Pipeline registers; payloads only move on a load so held output is stable.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_q <= '0;
      s1_q  <= '0;
      out_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (load1) s1_q  <= s1_d;
      if (load2) out_q <= out_d;
    end
  end

  assign out_valid  = vld_q[2];
  assign sign_large = out_q.sign_large;
  assign eff_sub    = out_q.eff_sub;
  assign exp_max    = out_q.exp_max;
  assign frac_large = out_q.frac_large;
  assign frac_small = out_q.frac_small;
  assign sticky     = out_q.sticky;
  assign special    = out_q.special;

endmodule
